// File: rtl/game_undo_ctrl.sv
// Purpose : four-deep circular LIFO of game-state snapshots with a one-cycle restore FSM.
// Latency : undo_req sampled at edge t -> restore_valid/restore_state valid during cycle t+1.
// Backpr. : none; requests arriving while busy (RESTORE) are dropped, except clear which is honoured.
//
// Ports:
//   clk, rst       : clock and synchronous active-high reset
//   cur_state      : live game state, captured on push_req
//   push_req       : save cur_state as newest snapshot
//   undo_req       : restore newest snapshot (or pulse undo_empty if none)
//   clear_req      : discard all history
//   sel            : slot index driving the 4-to-1 restore mux
//   restore_state  : snapshot currently selected by sel
//   restore_valid  : one-cycle pulse, restore_state should be loaded
//   undo_empty     : one-cycle pulse, undo refused (no history)
//   depth          : number of stored snapshots, 0..4
//   busy           : high while in RESTORE
module game_undo_ctrl #(
  parameter int N = 134
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] cur_state,
  input  logic         push_req,
  input  logic         undo_req,
  input  logic         clear_req,
  output logic [1:0]   sel,
  output logic [N-1:0] restore_state,
  output logic         restore_valid,
  output logic         undo_empty,
  output logic [2:0]   depth,
  output logic         busy
);

  typedef enum logic {
    IDLE    = 1'b0,
    RESTORE = 1'b1
  } state_e;

  state_e       state_q, state_d;
  logic [1:0]   wr_ptr_q, wr_ptr_d;
  logic [2:0]   count_q, count_d;
  logic [1:0]   sel_q, sel_d;
  logic         undo_empty_q, undo_empty_d;
  logic         slot_we;
  logic [N-1:0] slot_q [4];

  // Control state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      wr_ptr_q     <= 2'd0;
      count_q      <= 3'd0;
      sel_q        <= 2'd0;
      undo_empty_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      sel_q        <= sel_d;
      undo_empty_q <= undo_empty_d;
    end
  end

  // Snapshot storage is not reset: count gates what is readable, so stale
  // contents can never be presented as a valid restore.
  always_ff @(posedge clk) begin
    if (slot_we) begin
      slot_q[wr_ptr_q] <= cur_state;
    end
  end

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    sel_d        = sel_q;
    undo_empty_d = 1'b0;
    slot_we      = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Priority clear > undo > push; losers are dropped, not queued.
        if (clear_req) begin
          count_d  = 3'd0;
          wr_ptr_d = 2'd0;
        end else if (undo_req) begin
          if (count_q != 3'd0) begin
            sel_d    = wr_ptr_q - 2'd1;
            wr_ptr_d = wr_ptr_q - 2'd1;
            count_d  = count_q - 3'd1;
            state_d  = RESTORE;
          end else begin
            undo_empty_d = 1'b1;
          end
        end else if (push_req) begin
          slot_we  = 1'b1;
          wr_ptr_d = wr_ptr_q + 2'd1;
          // When full, the write lands on the oldest slot; depth saturates.
          count_d  = (count_q == 3'd4) ? 3'd4 : count_q + 3'd1;
        end
      end
      RESTORE: begin
        // The restore pulse completes this cycle regardless; clear still wipes history.
        state_d = IDLE;
        if (clear_req) begin
          count_d  = 3'd0;
          wr_ptr_d = 2'd0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign sel           = sel_q;
  assign restore_state = slot_q[sel_q];
  assign restore_valid = (state_q == RESTORE);
  assign busy          = (state_q == RESTORE);
  assign undo_empty    = undo_empty_q;
  assign depth         = count_q;

endmodule

// File: tb/tb_game_undo_ctrl.sv
module tb_game_undo_ctrl;

  localparam int N = 134;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] cur_state;
  logic         push_req;
  logic         undo_req;
  logic         clear_req;
  logic [1:0]   sel;
  logic [N-1:0] restore_state;
  logic         restore_valid;
  logic         undo_empty;
  logic [2:0]   depth;
  logic         busy;

  typedef struct {
    logic         empty;
    logic [N-1:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  game_undo_ctrl #(.N(N)) dut (
    .clk           (clk),
    .rst           (rst),
    .cur_state     (cur_state),
    .push_req      (push_req),
    .undo_req      (undo_req),
    .clear_req     (clear_req),
    .sel           (sel),
    .restore_state (restore_state),
    .restore_valid (restore_valid),
    .undo_empty    (undo_empty),
    .depth         (depth),
    .busy          (busy)
  );

  task automatic check(input string tag, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  // Scoreboard: every restore_valid / undo_empty pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (restore_valid === 1'b1 || undo_empty === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_out", {undo_empty, restore_valid}, 2'b00);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_kind", {undo_empty, restore_valid}, e.empty ? 2'b10 : 2'b01);
        if (!e.empty) check("sb_restore_state", restore_state, e.val);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_push(input logic [N-1:0] v);
    cur_state = v;
    push_req  = 1'b1;
    tick();
    push_req  = 1'b0;
  endtask

  task automatic expect_restore(input logic [N-1:0] v);
    exp_t e;
    e.empty = 1'b0;
    e.val   = v;
    sb_q.push_back(e);
  endtask

  task automatic expect_empty();
    exp_t e;
    e.empty = 1'b1;
    e.val   = '0;
    sb_q.push_back(e);
  endtask

  task automatic do_undo();
    undo_req = 1'b1;
    tick();
    undo_req = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cur_state = '0; push_req = 1'b0; undo_req = 1'b0; clear_req = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check("reset_depth", depth, 0);
    check("reset_busy", busy, 0);
    check("reset_rv", restore_valid, 0);
    check("reset_ue", undo_empty, 0);
    check("reset_sel", sel, 0);

    // Undo with no history
    expect_empty();
    do_undo();
    check("empty_ue", undo_empty, 1);
    check("empty_rv", restore_valid, 0);
    check("empty_depth", depth, 0);
    tick();
    check("empty_ue_pulse", undo_empty, 0);

    // Push 1,2,3 then undo thrice, two cycles apart
    for (int i = 1; i <= 3; i++) do_push(N'(i));
    check("p3_depth", depth, 3);
    for (int i = 3; i >= 1; i--) begin
      expect_restore(N'(i));
      do_undo();
      check("u3_rv", restore_valid, 1);
      check("u3_busy", busy, 1);
      check("u3_val", restore_state, N'(i));
      check("u3_sel", sel, i - 1);
      check("u3_depth", depth, i - 1);
      tick();
      check("u3_rv_pulse", restore_valid, 0);
      check("u3_busy_pulse", busy, 0);
    end

    // Overflow: five pushes, depth saturates at 4, oldest overwritten
    for (int i = 10; i <= 14; i++) begin
      do_push(N'(i));
      check("ovf_depth", depth, (i - 9 > 4) ? 4 : i - 9);
    end
    for (int i = 14; i >= 11; i--) begin
      expect_restore(N'(i));
      do_undo();
      check("ovf_val", restore_state, N'(i));
      check("ovf_depth_dn", depth, i - 11);
      tick();
    end
    expect_empty();
    do_undo();
    check("ovf_ue", undo_empty, 1);
    check("ovf_rv", restore_valid, 0);
    tick();

    // Push and undo together: undo wins, pushed value is dropped
    do_push(N'(20));
    do_push(N'(21));
    check("pu_depth2", depth, 2);
    cur_state = N'(99);
    push_req = 1'b1;
    expect_restore(N'(21));
    do_undo();
    push_req = 1'b0;
    check("pu_val", restore_state, N'(21));
    check("pu_depth", depth, 1);
    tick();
    expect_restore(N'(20));
    do_undo();
    check("pu_next_val", restore_state, N'(20));
    check("pu_depth0", depth, 0);
    tick();

    // Clear beats undo: no restore, history gone
    for (int i = 30; i <= 32; i++) do_push(N'(i));
    check("cu_depth3", depth, 3);
    clear_req = 1'b1;
    do_undo();
    clear_req = 1'b0;
    check("cu_rv", restore_valid, 0);
    check("cu_depth", depth, 0);
    tick();
    expect_empty();
    do_undo();
    check("cu_ue", undo_empty, 1);
    tick();

    // Clear during RESTORE: pulse completes, history wiped
    do_push(N'(40));
    do_push(N'(41));
    expect_restore(N'(41));
    do_undo();
    check("cr_rv", restore_valid, 1);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    check("cr_rv_after", restore_valid, 0);
    check("cr_depth", depth, 0);
    tick();

    // Reset during RESTORE aborts the pulse
    for (int i = 50; i <= 52; i++) do_push(N'(i));
    expect_restore(N'(52));
    do_undo();
    check("rr_rv", restore_valid, 1);
    check("rr_sel", sel, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rr_rv_after", restore_valid, 0);
    check("rr_depth", depth, 0);
    check("rr_sel0", sel, 0);
    check("rr_busy", busy, 0);
    tick(); tick();

    check("sb_drain", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/game_undo_ctrl.md
GAME_UNDO_CTRL -- requirements
Module: game_undo_ctrl

Interface
REQ-001 The block SHALL have parameter N, default 134, which is the width of one packed game-state word.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port cur_state, input, N bits: the live game state to snapshot.
REQ-005 The block SHALL have port push_req, input, 1 bit: single-cycle pulse to save cur_state before a move commits.
REQ-006 The block SHALL have port undo_req, input, 1 bit: single-cycle pulse requesting restore of the newest snapshot.
REQ-007 The block SHALL have port clear_req, input, 1 bit: single-cycle pulse that discards all history, e.g. on level load or restart.
REQ-008 The block SHALL have port sel, output, 2 bits: select for the 4-to-1 game-state mux, indexing snapshot slot 0..3.
REQ-009 The block SHALL have port restore_state, output, N bits: the snapshot selected by sel.
REQ-010 The block SHALL have port restore_valid, output, 1 bit: one-cycle pulse; restore_state is valid to load into the game register.
REQ-011 The block SHALL have port undo_empty, output, 1 bit: one-cycle pulse; an undo was refused because no history exists.
REQ-012 The block SHALL have port depth, output, 3 bits: the number of stored snapshots, 0..4.
REQ-013 The block SHALL have port busy, output, 1 bit: high while in the RESTORE state.

Function
REQ-014 Storage SHALL be four N-bit snapshot slots plus wr_ptr (2 bits, next slot to write) and count (3 bits, 0..4), organised as a circular LIFO.
REQ-015 The FSM SHALL have exactly two states, IDLE and RESTORE.
REQ-016 In IDLE, request priority per cycle SHALL be clear_req > undo_req > push_req; lower-priority requests in the same cycle are dropped, not queued.
REQ-017 Clear in IDLE SHALL, at the next edge, set count=0 and wr_ptr=0; slot contents are left unchanged and unreadable.
REQ-018 Push in IDLE SHALL, at the next edge, write cur_state into slot[wr_ptr] and set wr_ptr=wr_ptr+1 mod 4.
REQ-019 Push SHALL set count=min(count+1,4); a push at count==4 overwrites the oldest slot, and count stays 4.
REQ-020 Undo in IDLE with count>0 SHALL, at the next edge, set sel=wr_ptr-1 mod 4, wr_ptr=wr_ptr-1 mod 4, count=count-1, and move the FSM to RESTORE.
REQ-021 Undo in IDLE with count==0 SHALL assert undo_empty for exactly one cycle after the edge and leave all state unchanged; the FSM stays in IDLE.
REQ-022 RESTORE SHALL last exactly one cycle, with restore_valid=1, busy=1, and restore_state=slot[sel]; the FSM then returns to IDLE.
REQ-023 Undo latency SHALL be: undo_req sampled at edge t, restore_valid high during cycle t+1.
REQ-024 In RESTORE, push_req and undo_req SHALL be ignored; clear_req SHALL be honoured per REQ-017 while restore_valid still completes that cycle.
REQ-025 restore_state SHALL be combinational from sel and the slots, so it always reflects the slot sel points to; sel holds its value until the next accepted undo.
REQ-026 depth SHALL equal count at all times.
REQ-027 Consecutive undos SHALL return snapshots newest-first; after four pushes followed by four undos, count==0.

Reset
REQ-028 With rst=1 at a clock edge, the block SHALL set FSM=IDLE, wr_ptr=0, count=0, sel=0, restore_valid=0, undo_empty=0, and busy=0.
REQ-029 rst SHALL override all requests in the same cycle, and rst during RESTORE SHALL abort the pulse, leaving restore_valid=0 in the following cycle.
REQ-030 On reset, slot contents need not be cleared and SHALL NOT be observable as valid until pushed again.

Verification
REQ-031 The bench SHALL cover: reset, then undo_req -> undo_empty pulse for 1 cycle, restore_valid=0, depth=0.
REQ-032 The bench SHALL cover: push A=1, B=2, C=3, then three undos spaced 2 cycles apart -> restore_state 3, 2, 1, each one cycle after its undo_req, with depth 2, 1, 0.
REQ-033 The bench SHALL cover: five pushes of values 10..14, then undo x5 -> restore 14, 13, 12, 11, then undo_empty on the fifth; depth peaks at 4.
REQ-034 The bench SHALL cover: push_req and undo_req in the same cycle with depth=2 -> undo wins, depth=1, and the pushed value is not stored.
REQ-035 The bench SHALL cover: clear_req together with undo_req at depth=3 -> no restore_valid, depth=0, and a subsequent undo gives undo_empty.
REQ-036 The bench SHALL cover: rst asserted during RESTORE -> restore_valid=0 in the next cycle, depth=0, sel=0.
